// File: rtl/regfile_write_scheduler.sv
// Two-requester writeback scheduler for the single register-file write port; R15 writes go to pc_load/pc_data.
// Optional macro RR_ARB_EN: round-robin tie-break. When it is undefined, requester 0 always wins a tie.

module regfile_write_hold #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             grant,
  input  logic [3:0]       dest,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             hold_valid,
  output logic [3:0]       hold_dest,
  output logic [WIDTH-1:0] hold_data
);
  // A granted slot drains on this edge, so it can reload in the same cycle.
  assign ready = ~hold_valid | grant;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_dest  <= '0;
      hold_data  <= '0;
    end else if (valid && ready) begin
      hold_valid <= 1'b1;
      hold_dest  <= dest;
      hold_data  <= data;
    end else if (grant) begin
      hold_valid <= 1'b0;
    end
  end
endmodule

module regfile_write_scheduler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_dest,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_dest,
  input  logic [WIDTH-1:0] req1_data,
  output logic             write_enable,
  output logic [3:0]       Destination_select,
  output logic [WIDTH-1:0] DATA,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_data,
  output logic [15:0]      pending_mask
);
  logic [1:0]            req_valid, req_ready, hold_valid, grant;
  logic [1:0][3:0]       req_dest, hold_dest;
  logic [1:0][WIDTH-1:0] req_data, hold_data;
  logic                  sel;
  logic [3:0]            sel_dest;
  logic [WIDTH-1:0]      sel_data;

  assign req_valid  = {req1_valid, req0_valid};
  assign req_dest   = {req1_dest, req0_dest};
  assign req_data   = {req1_data, req0_data};
  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  for (genvar i = 0; i < 2; i++) begin : g_hold
    regfile_write_hold #(.WIDTH(WIDTH)) u_hold (
      .clk        (clk),
      .reset      (reset),
      .valid      (req_valid[i]),
      .grant      (grant[i]),
      .dest       (req_dest[i]),
      .data       (req_data[i]),
      .ready      (req_ready[i]),
      .hold_valid (hold_valid[i]),
      .hold_dest  (hold_dest[i]),
      .hold_data  (hold_data[i])
    );
  end

`ifdef RR_ARB_EN
  logic rr_ptr;

  // On a tie the winner is rr_ptr, so flipping hands priority to the loser.
  always_ff @(posedge clk) begin
    if (!reset)          rr_ptr <= 1'b0;
    else if (&hold_valid) rr_ptr <= ~rr_ptr;
  end

  assign grant[0] = hold_valid[0] & (~hold_valid[1] | ~rr_ptr);
  assign grant[1] = hold_valid[1] & (~hold_valid[0] |  rr_ptr);
`else
  assign grant[0] = hold_valid[0];
  assign grant[1] = hold_valid[1] & ~hold_valid[0];
`endif

  assign sel      = grant[1];
  assign sel_dest = hold_dest[sel];
  assign sel_data = hold_data[sel];

  // Payload registers only move on the path actually taken, so they hold across idle cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      write_enable       <= 1'b0;
      pc_load            <= 1'b0;
      Destination_select <= '0;
      DATA               <= '0;
      pc_data            <= '0;
    end else if (|grant) begin
      if (sel_dest == 4'd15) begin
        write_enable <= 1'b0;
        pc_load      <= 1'b1;
        pc_data      <= sel_data;
      end else begin
        write_enable       <= 1'b1;
        pc_load            <= 1'b0;
        Destination_select <= sel_dest;
        DATA               <= sel_data;
      end
    end else begin
      write_enable <= 1'b0;
      pc_load      <= 1'b0;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < 2; i++)
      if (hold_valid[i]) pending_mask[hold_dest[i]] = 1'b1;
  end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench for regfile_write_scheduler: a cycle model predicts each issue, queued and compared a cycle later.
module tb_regfile_write_scheduler;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [3:0]       req0_dest = '0, req1_dest = '0;
  logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
  logic             write_enable, pc_load;
  logic [3:0]       Destination_select;
  logic [WIDTH-1:0] DATA, pc_data;
  logic [15:0]      pending_mask;

  regfile_write_scheduler #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dest(req0_dest), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dest(req1_dest), .req1_data(req1_data),
    .write_enable(write_enable), .Destination_select(Destination_select), .DATA(DATA),
    .pc_load(pc_load), .pc_data(pc_data), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             pc;
    logic [3:0]       dest;
    logic [WIDTH-1:0] data;
  } wr_t;

  wr_t              exp_q[$];
  logic [WIDTH-1:0] we_log[$];
  logic [3:0]       we_dlog[$];
  int               checks = 0, errors = 0;
  int               cnt_pc = 0, cnt_p15 = 0, cnt_p7 = 0;
  logic             acc0 = 1'b0, acc1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state (as of the next rising edge)
  logic [1:0]            m_hv = '0;
  logic [1:0][3:0]       m_dest = '0;
  logic [1:0][WIDTH-1:0] m_data = '0;
  logic                  m_rr = 1'b0;
  logic [3:0]            last_dest = '0;
  logic [WIDTH-1:0]      last_data = '0, last_pc = '0;
  wr_t                   e;
  logic [1:0]            g, rdy, rv;
  logic [15:0]           pm;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("pc_load", 32'(pc_load), 32'(e.pc));
      chk("write_enable", 32'(write_enable), 32'(!e.pc));
      if (e.pc) last_pc = e.data;
      else begin
        last_dest = e.dest;
        last_data = e.data;
      end
    end else begin
      chk("idle_write_enable", 32'(write_enable), 32'(0));
      chk("idle_pc_load", 32'(pc_load), 32'(0));
    end
    chk("Destination_select", 32'(Destination_select), 32'(last_dest));
    chk("DATA", DATA, last_data);
    chk("pc_data", pc_data, last_pc);
    if (write_enable === 1'b1) begin
      we_log.push_back(DATA);
      we_dlog.push_back(Destination_select);
    end
    if (pc_load === 1'b1) cnt_pc++;
    if (pending_mask[15] === 1'b1) cnt_p15++;
    if (pending_mask[7] === 1'b1) cnt_p7++;

    g = '0;
    if (m_hv[0] && m_hv[1]) begin
`ifdef RR_ARB_EN
      g[m_rr] = 1'b1;
`else
      g[0] = 1'b1;
`endif
    end else g = m_hv;
    rdy = ~m_hv | g;
    chk("req0_ready", 32'(req0_ready), 32'(rdy[0]));
    chk("req1_ready", 32'(req1_ready), 32'(rdy[1]));
    pm = '0;
    for (int i = 0; i < 2; i++) if (m_hv[i]) pm[m_dest[i]] = 1'b1;
    chk("pending_mask", 32'(pending_mask), 32'(pm));

    rv = {req1_valid, req0_valid};
    if (!reset) begin
      m_hv = '0;
      m_rr = 1'b0;
      exp_q.delete();
      last_dest = '0;
      last_data = '0;
      last_pc   = '0;
    end else begin
      if (g != 0) exp_q.push_back({m_dest[g[1]] == 4'd15, m_dest[g[1]], m_data[g[1]]});
      if (m_hv[0] && m_hv[1]) m_rr = ~m_rr;
      for (int i = 0; i < 2; i++) begin
        if (rv[i] && rdy[i]) begin
          m_hv[i]   = 1'b1;
          m_dest[i] = (i == 0) ? req0_dest : req1_dest;
          m_data[i] = (i == 0) ? req0_data : req1_data;
        end else if (g[i]) m_hv[i] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    acc0 = req0_valid & req0_ready;
    acc1 = req1_valid & req1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    we_log.delete();
    we_dlog.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, k4, k5;
    logic [WIDTH-1:0] exp_d;

    // 1: reset with a live request underneath it
    reset = 1'b0; req0_valid = 1'b1; req0_dest = 4'd3; req0_data = 32'h33;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_ready0", 32'(req0_ready), 32'(1));
    chk("t1_pending", 32'(pending_mask), 32'(0));
    chk("t1_we", 32'(write_enable), 32'(0));
    @(posedge clk); #1;
    chk("t1_no_writes", 32'(we_log.size()), 32'(0));

    // 2: lone stream from requester 0
    clear_log();
    for (int k = 1; k <= 3; k++) begin
      req0_valid = 1'b1; req0_dest = 4'(k); req0_data = 32'hA0 + 32'(k);
      tick();
      chk("t2_accept", 32'(acc0), 32'(1));
    end
    req0_valid = 1'b0;
    repeat (4) tick();
    chk("t2_count", 32'(we_log.size()), 32'(3));
    for (int k = 0; k < 3 && k < we_log.size(); k++) begin
      chk("t2_dest", 32'(we_dlog[k]), 32'(k + 1));
      chk("t2_data", we_log[k], 32'hA1 + 32'(k));
    end

    // 3: both requesters streaming
    clear_log();
    n0 = 0; n1 = 0;
    for (int c = 0; c < 8; c++) begin
      req0_valid = 1'b1; req0_dest = 4'd4; req0_data = 32'h10 + 32'(n0);
      req1_valid = 1'b1; req1_dest = 4'd5; req1_data = 32'h20 + 32'(n1);
      tick();
      if (acc0) n0++;
      if (acc1) n1++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) tick();
    chk("t3_total", 32'(we_log.size()), 32'(n0 + n1));
    k4 = 0; k5 = 0;
    for (int j = 0; j < we_log.size(); j++) begin
      if (we_dlog[j] == 4'd4) begin
        chk("t3_d4", we_log[j], 32'h10 + 32'(k4)); k4++;
      end else begin
        chk("t3_d5", we_log[j], 32'h20 + 32'(k5)); k5++;
      end
`ifdef RR_ARB_EN
      if (j > 0) chk("t3_alternate", 32'(we_dlog[j] != we_dlog[j-1]), 32'(1));
`endif
    end
    chk("t3_n0", 32'(k4), 32'(n0));
    chk("t3_n1", 32'(k5), 32'(n1));
`ifndef RR_ARB_EN
    chk("t3_starve", 32'(n1), 32'(1));
    if (we_dlog.size() > 0) chk("t3_req1_last", 32'(we_dlog[we_dlog.size()-1]), 32'(5));
`endif

    // 4: R15 goes to the PC path
    clear_log();
    cnt_pc = 0; cnt_p15 = 0;
    req1_valid = 1'b1; req1_dest = 4'd15; req1_data = 32'h0000_0100;
    tick();
    req1_valid = 1'b0;
    repeat (4) tick();
    chk("t4_pc_load_cycles", 32'(cnt_pc), 32'(1));
    chk("t4_pending15_cycles", 32'(cnt_p15), 32'(1));
    chk("t4_pc_data", pc_data, 32'h100);
    chk("t4_no_rf_write", 32'(we_log.size()), 32'(0));

    // 5: same destination from both in one cycle, rr_ptr freshly reset
    reset = 1'b0; tick(); reset = 1'b1;
    clear_log();
    cnt_p7 = 0;
    req0_valid = 1'b1; req0_dest = 4'd7; req0_data = 32'h55;
    req1_valid = 1'b1; req1_dest = 4'd7; req1_data = 32'hAA;
    tick();
    chk("t5_accept", 32'({acc1, acc0}), 32'(3));
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();
    chk("t5_count", 32'(we_log.size()), 32'(2));
    if (we_log.size() == 2) begin
      chk("t5_first", we_log[0], 32'h55);
      chk("t5_second", we_log[1], 32'hAA);
    end
    chk("t5_pending7_cycles", 32'(cnt_p7), 32'(2));
    chk("t5_final", DATA, 32'hAA);

    // 6: reset while both holds are full
    clear_log();
    req0_valid = 1'b1; req0_dest = 4'd8; req0_data = 32'h88;
    req1_valid = 1'b1; req1_dest = 4'd9; req1_data = 32'h99;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t6_pending_before", 32'(pending_mask), 32'h0300);
    reset = 1'b0;
    tick();
    chk("t6_we", 32'(write_enable), 32'(0));
    chk("t6_pc_load", 32'(pc_load), 32'(0));
    chk("t6_pending", 32'(pending_mask), 32'(0));
    reset = 1'b1;
    req0_valid = 1'b1; req0_dest = 4'd10; req0_data = 32'hA;
    req1_valid = 1'b1; req1_dest = 4'd11; req1_data = 32'hB;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();
    chk("t6_count", 32'(we_log.size()), 32'(2));
    if (we_log.size() == 2) begin
      chk("t6_first_dest", 32'(we_dlog[0]), 32'(10));
      chk("t6_second_dest", 32'(we_dlog[1]), 32'(11));
    end

    // random traffic with honest handshakes; the model checks every cycle
    acc0 = 1'b0; acc1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid || acc0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_dest  = 4'($urandom_range(0, 15));
        req0_data  = WIDTH'($urandom);
      end
      if (!req1_valid || acc1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_dest  = 4'($urandom_range(0, 15));
        req1_data  = WIDTH'($urandom);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();
    chk("final_pending", 32'(pending_mask), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
